// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for four requesters with registered one-hot grant.
// Optional hold limit enabled by defining ARB_TIMEOUT_EN.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       En,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic       to_q, to_d;
  logic [1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] ptr;
  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] win;
  logic       any_req;
  logic       owner_req;
  logic       hold_hit;
  logic       rel;

  if (MAX_HOLD < 1 || MAX_HOLD > 255 ||
      (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cfg
    $error("rr_decode_arbiter: bad MAX_HOLD/CNT_W");
  end

  // Winner search: rotate req so bit 0 is the slot after last owner.
  always_comb begin
    ptr = last_q + 2'd1;
    rot = req;
    unique case (ptr)
      2'd0: rot = req;
      2'd1: rot = {req[0], req[3:1]};
      2'd2: rot = {req[1:0], req[3:2]};
      2'd3: rot = {req[2:0], req[3]};
      default: rot = req;
    endcase
    off = 2'd0;
    priority case (1'b1)
      rot[0]: off = 2'd0;
      rot[1]: off = 2'd1;
      rot[2]: off = 2'd2;
      rot[3]: off = 2'd3;
      default: off = 2'd0;
    endcase
    win       = ptr + off;
    any_req   = |req;
    owner_req = req[idx_q];
`ifdef ARB_TIMEOUT_EN
    hold_hit  = owner_req && (cnt_q == CNT_W'(MAX_HOLD));
`else
    hold_hit  = 1'b0;
`endif
    rel       = !owner_req || !En || hold_hit;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (En && any_req) state_d = S_GRANT;
      S_GRANT: if (rel) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant, pointer, hold counter and timeout next values.
  always_comb begin
    gnt_d  = gnt_q;
    idx_d  = idx_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    to_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (En && any_req) begin
          gnt_d = 4'b0001 << win;
          idx_d = win;
          cnt_d = CNT_W'(1);
        end else begin
          gnt_d = 4'b0000;
        end
      end
      S_GRANT: begin
        if (rel) begin
          gnt_d  = 4'b0000;
          last_d = idx_q;
          cnt_d  = '0;
          to_d   = hold_hit;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: gnt_d = 4'b0000;
    endcase
    vld_d = |gnt_d;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'b00;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      last_q  <= 2'b11;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: vector table plus hold sequences.
// Expected outputs are queued at drive time and checked after the edge.
module tb_rr_decode_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       En  = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  rr_decode_arbiter #(
    .MAX_HOLD(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .En(En),
    .req(req),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       e;
    logic [3:0] rq;
    logic [3:0] g;
    logic [1:0] i;
    logic       t;
    string      nm;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [1:0] i;
    logic       v;
    logic       t;
    string      nm;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic add(input logic r, input logic e,
                     input logic [3:0] rq, input logic [3:0] g,
                     input logic [1:0] i, input string nm);
    vec_t v;
    v.r = r; v.e = e; v.rq = rq;
    v.g = g; v.i = i; v.t = 1'b0; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic check();
    exp_t x;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got output with no expectation");
      return;
    end
    x = sb.pop_front();
    if (gnt !== x.g || gnt_idx !== x.i || gnt_vld !== x.v ||
        timeout !== x.t) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b idx=%0d vld=%b to=%b, want gnt=%b idx=%0d vld=%b to=%b",
               x.nm, gnt, gnt_idx, gnt_vld, timeout, x.g, x.i, x.v, x.t);
    end
  endtask

  task automatic step(input logic r, input logic e,
                      input logic [3:0] rq, input logic [3:0] g,
                      input logic [1:0] i, input logic t,
                      input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; En = e; req = rq;
    x.g = g; x.i = i; x.v = |g; x.t = t; x.nm = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    // basic grant, release, bubble, next winner
    add(1, 0, 4'b0000, 4'b0000, 2'd0, "t1_reset");
    add(0, 1, 4'b0101, 4'b0001, 2'd0, "t1_grant0");
    add(0, 1, 4'b0101, 4'b0001, 2'd0, "t1_hold0");
    add(0, 1, 4'b0100, 4'b0000, 2'd0, "t1_bubble");
    add(0, 1, 4'b0100, 4'b0100, 2'd2, "t1_grant2");
    add(0, 1, 4'b0000, 4'b0000, 2'd2, "t1_drop2");
    add(0, 0, 4'b1111, 4'b0000, 2'd2, "t1_idle_en0");
    // rotation with all requesting
    add(1, 1, 4'b1111, 4'b0000, 2'd0, "t2_reset");
    for (int k = 0; k < 4; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << k;
      for (int c = 0; c < 3; c++)
        add(0, 1, 4'b1111, oh, 2'(k), $sformatf("t2_own%0d_c%0d", k, c));
      add(0, 1, 4'b1111 & ~oh, 4'b0000, 2'(k), $sformatf("t2_gap%0d", k));
    end
    add(0, 1, 4'b1111, 4'b0001, 2'd0, "t2_wrap0");
    add(0, 1, 4'b1110, 4'b0000, 2'd0, "t2_wrap_gap");
    // En drop during grant
    add(1, 0, 4'b0000, 4'b0000, 2'd0, "t3a_reset");
    add(0, 1, 4'b0010, 4'b0010, 2'd1, "t3a_grant1");
    add(0, 1, 4'b0010, 4'b0010, 2'd1, "t3a_hold1");
    add(0, 0, 4'b0110, 4'b0000, 2'd1, "t3a_en0_a");
    add(0, 0, 4'b0110, 4'b0000, 2'd1, "t3a_en0_b");
    add(0, 1, 4'b0110, 4'b0100, 2'd2, "t3a_win2");
    add(1, 0, 4'b0000, 4'b0000, 2'd0, "t3b_reset");
    add(0, 1, 4'b0010, 4'b0010, 2'd1, "t3b_grant1");
    add(0, 0, 4'b0010, 4'b0000, 2'd1, "t3b_en0_a");
    add(0, 0, 4'b0010, 4'b0000, 2'd1, "t3b_en0_b");
    add(0, 1, 4'b0010, 4'b0010, 2'd1, "t3b_regrant1");
    // reset mid-grant
    add(1, 0, 4'b0000, 4'b0000, 2'd0, "t4_reset");
    add(0, 1, 4'b1000, 4'b1000, 2'd3, "t4_grant3");
    add(0, 1, 4'b1000, 4'b1000, 2'd3, "t4_hold3");
    add(1, 1, 4'b1001, 4'b0000, 2'd0, "t4_rst_mid");
    add(0, 1, 4'b1001, 4'b0001, 2'd0, "t4_grant0");
    add(0, 1, 4'b1000, 4'b0000, 2'd0, "t4_bubble");
    add(0, 1, 4'b1000, 4'b1000, 2'd3, "t4_grant3b");

    foreach (tbl[n])
      step(tbl[n].r, tbl[n].e, tbl[n].rq, tbl[n].g,
           tbl[n].i, tbl[n].t, tbl[n].nm);

`ifdef ARB_TIMEOUT_EN
    // bounded hold: alternate owners 0 and 1 every 4 cycles
    step(1, 0, 4'b0000, 4'b0000, 2'd0, 1'b0, "t5_reset");
    for (int r = 0; r < 4; r++) begin
      logic [1:0] o;
      o = 2'(r % 2);
      for (int c = 0; c < 4; c++)
        step(0, 1, 4'b0011, 4'b0001 << o, o, 1'b0,
             $sformatf("t5_r%0d_own_c%0d", r, c));
      step(0, 1, 4'b0011, 4'b0000, o, 1'b1,
           $sformatf("t5_r%0d_timeout", r));
    end
`else
    // unbounded hold: single requester keeps the grant
    step(1, 0, 4'b0000, 4'b0000, 2'd0, 1'b0, "t6_reset");
    for (int c = 0; c < 300; c++)
      step(0, 1, 4'b0001, 4'b0001, 2'd0, 1'b0,
           $sformatf("t6_hold_c%0d", c));
`endif

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_left: got %0d pending, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
